// File: rtl/prince_sbox_layer_ctrl_if.sv
// Layer, randomness and gadget handshake bundle for the
// PRINCE masked S-box layer controller.
interface prince_sbox_layer_ctrl_if #(
  parameter int NIB = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [4*NIB-1:0] in_sh0;
  logic [4*NIB-1:0] in_sh1;
  logic             rnd_valid;
  logic [9:0]       rnd_data;
  logic             rnd_ready;
  logic [3:0]       sbox_in0;
  logic [3:0]       sbox_in1;
  logic [9:0]       sbox_ran;
  logic [3:0]       sbox_out0;
  logic [3:0]       sbox_out1;
  logic             out_valid;
  logic             out_ready;
  logic [4*NIB-1:0] out_sh0;
  logic [4*NIB-1:0] out_sh1;

  modport master (
    output in_valid, in_sh0, in_sh1,
    output rnd_valid, rnd_data,
    output sbox_out0, sbox_out1,
    output out_ready,
    input  in_ready, rnd_ready,
    input  sbox_in0, sbox_in1, sbox_ran,
    input  out_valid, out_sh0, out_sh1
  );

  modport slave (
    input  in_valid, in_sh0, in_sh1,
    input  rnd_valid, rnd_data,
    input  sbox_out0, sbox_out1,
    input  out_ready,
    output in_ready, rnd_ready,
    output sbox_in0, sbox_in1, sbox_ran,
    output out_valid, out_sh0, out_sh1
  );
endinterface

// File: rtl/prince_sbox_layer_ctrl.sv
// Sequences one masked PRINCE S-box layer nibble by nibble
// through an external one-cycle-latency gadget.
module prince_sbox_layer_ctrl #(
  parameter int NIB = 16
) (
  input  logic clk,
  input  logic rst,
  prince_sbox_layer_ctrl_if.slave bus
);
  localparam int W = 4 * NIB;
  localparam logic [4:0] NIB_C = 5'(NIB);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [W-1:0] sh0_q, sh0_d;
  logic [W-1:0] sh1_q, sh1_d;
  logic [W-1:0] res0_q, res0_d;
  logic [W-1:0] res1_q, res1_d;
  logic [4:0]   issue_cnt_q, issue_cnt_d;
  logic [4:0]   col_cnt_q, col_cnt_d;
  logic         dly_q, dly_d;
  logic [3:0]   idx_q, idx_d;
  logic [5:0]   ibase;
  logic [5:0]   rbase;
  logic         rnd_rdy;
  logic         issue;

  assign ibase = {issue_cnt_q[3:0], 2'b00};
  assign rbase = {idx_q, 2'b00};

  always_comb begin
    state_d       = state_q;
    sh0_d         = sh0_q;
    sh1_d         = sh1_q;
    res0_d        = res0_q;
    res1_d        = res1_q;
    issue_cnt_d   = issue_cnt_q;
    col_cnt_d     = col_cnt_q;
    dly_d         = 1'b0;
    idx_d         = idx_q;
    rnd_rdy       = 1'b0;
    issue         = 1'b0;
    bus.in_ready  = 1'b0;
    bus.sbox_in0  = '0;
    bus.sbox_in1  = '0;
    bus.sbox_ran  = '0;
    bus.out_valid = 1'b0;
    bus.out_sh0   = '0;
    bus.out_sh1   = '0;
    unique case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          sh0_d       = bus.in_sh0;
          sh1_d       = bus.in_sh1;
          issue_cnt_d = '0;
          col_cnt_d   = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        rnd_rdy = issue_cnt_q < NIB_C;
        issue   = rnd_rdy & bus.rnd_valid;
        if (issue) begin
          bus.sbox_in0 = sh0_q[ibase +: 4];
          bus.sbox_in1 = sh1_q[ibase +: 4];
          bus.sbox_ran = bus.rnd_data;
          dly_d        = 1'b1;
          idx_d        = issue_cnt_q[3:0];
          issue_cnt_d  = issue_cnt_q + 5'd1;
        end
        // gadget answer for the issue made one cycle earlier
        if (dly_q) begin
          res0_d[rbase +: 4] = bus.sbox_out0;
          res1_d[rbase +: 4] = bus.sbox_out1;
          col_cnt_d          = col_cnt_q + 5'd1;
        end
        if (col_cnt_q == NIB_C) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.out_sh0   = res0_q;
        bus.out_sh1   = res1_q;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rnd_ready = rnd_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sh0_q       <= '0;
      sh1_q       <= '0;
      res0_q      <= '0;
      res1_q      <= '0;
      issue_cnt_q <= '0;
      col_cnt_q   <= '0;
      dly_q       <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      sh0_q       <= sh0_d;
      sh1_q       <= sh1_d;
      res0_q      <= res0_d;
      res1_q      <= res1_d;
      issue_cnt_q <= issue_cnt_d;
      col_cnt_q   <= col_cnt_d;
      dly_q       <= dly_d;
      idx_q       <= idx_d;
    end
  end
endmodule

// File: tb/tb_prince_sbox_layer_ctrl.sv
// Random-stimulus bench for the S-box layer controller with a
// behavioural masked PRINCE S-box gadget and layer model.
module tb_prince_sbox_layer_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  prince_sbox_layer_ctrl_if #(.NIB(16)) b16 ();
  prince_sbox_layer_ctrl_if #(.NIB(1))  b1 ();

  prince_sbox_layer_ctrl #(.NIB(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (b16.slave)
  );

  prince_sbox_layer_ctrl #(.NIB(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  function automatic logic [3:0] sb(input logic [3:0] x);
    case (x)
      4'h0: sb = 4'hB; 4'h1: sb = 4'hF; 4'h2: sb = 4'h3; 4'h3: sb = 4'h2;
      4'h4: sb = 4'hA; 4'h5: sb = 4'hC; 4'h6: sb = 4'h9; 4'h7: sb = 4'h1;
      4'h8: sb = 4'h6; 4'h9: sb = 4'h7; 4'hA: sb = 4'h8; 4'hB: sb = 4'h0;
      4'hC: sb = 4'hE; 4'hD: sb = 4'h5; 4'hE: sb = 4'hD; default: sb = 4'h4;
    endcase
  endfunction

  function automatic logic [63:0] ref_layer(input logic [63:0] x, input int n);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[4*i +: 4] = sb(x[4*i +: 4]);
    return r;
  endfunction

  // masked gadget: S(x0^x1) split with a fresh mask taken from the randomness
  always @(posedge clk) begin
    b16.sbox_out0 <= sb(b16.sbox_in0 ^ b16.sbox_in1) ^ b16.sbox_ran[7:4];
    b16.sbox_out1 <= b16.sbox_ran[7:4];
    b1.sbox_out0  <= sb(b1.sbox_in0 ^ b1.sbox_in1) ^ b1.sbox_ran[3:0];
    b1.sbox_out1  <= b1.sbox_ran[3:0];
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run16(input logic [63:0] a0, input logic [63:0] a1,
                       input int gs, input int gl, input int hold,
                       input int rst_at, input string nm);
    logic [9:0]  gen[$];
    logic [9:0]  trace[$];
    logic [9:0]  w;
    logic [63:0] e, r0, r1;
    int          nis, lat, dup;
    bit          fresh, aborted;
    e = ref_layer(a0 ^ a1, 16);
    @(negedge clk);
    #1;
    chk({nm, "_in_ready"}, 64'(b16.in_ready), 64'd1);
    b16.in_valid  = 1'b1;
    b16.in_sh0    = a0;
    b16.in_sh1    = a1;
    b16.rnd_valid = 1'b0;
    b16.out_ready = 1'b0;
    nis = 0;
    lat = -1;
    aborted = 1'b0;
    for (int k = 0; k < 80 && lat < 0 && !aborted; k++) begin
      @(negedge clk);
      b16.in_valid  = 1'($urandom_range(0, 1));
      b16.in_sh0    = {$urandom, $urandom};
      b16.in_sh1    = {$urandom, $urandom};
      b16.rnd_valid = !(k >= gs && k < gs + gl);
      do begin
        w = 10'($urandom);
        fresh = 1'b1;
        foreach (gen[j]) if (gen[j] == w) fresh = 1'b0;
      end while (!fresh);
      gen.push_back(w);
      b16.rnd_data = w;
      #1;
      if (b16.out_valid) begin
        lat = k;
      end else begin
        chk({nm, "_osh0_zero"}, b16.out_sh0, 64'd0);
        chk({nm, "_osh1_zero"}, b16.out_sh1, 64'd0);
        chk({nm, "_rnd_ready"}, 64'(b16.rnd_ready), 64'(nis < 16));
        if (b16.rnd_valid && nis < 16) begin
          chk({nm, "_sbox_ran"}, 64'(b16.sbox_ran), 64'(w));
          chk({nm, "_sbox_in0"}, 64'(b16.sbox_in0), 64'(a0[4*nis +: 4]));
          chk({nm, "_sbox_in1"}, 64'(b16.sbox_in1), 64'(a1[4*nis +: 4]));
          trace.push_back(b16.sbox_ran);
          if (nis == rst_at) begin
            rst = 1'b1;
            aborted = 1'b1;
          end
          nis++;
        end else begin
          chk({nm, "_idle_ran"}, 64'(b16.sbox_ran), 64'd0);
          chk({nm, "_idle_in"}, 64'({b16.sbox_in0, b16.sbox_in1}), 64'd0);
        end
      end
    end
    if (aborted) begin
      @(negedge clk);
      rst = 1'b0;
      b16.in_valid = 1'b0;
      #1;
      chk({nm, "_rst_in_ready"}, 64'(b16.in_ready), 64'd1);
      chk({nm, "_rst_rnd_ready"}, 64'(b16.rnd_ready), 64'd0);
      chk({nm, "_rst_sbox"}, 64'({b16.sbox_ran, b16.sbox_in0, b16.sbox_in1}), 64'd0);
      chk({nm, "_rst_sh0q"}, dut16.sh0_q, 64'd0);
      chk({nm, "_rst_sh1q"}, dut16.sh1_q, 64'd0);
      chk({nm, "_rst_res0q"}, dut16.res0_q, 64'd0);
      chk({nm, "_rst_res1q"}, dut16.res1_q, 64'd0);
      for (int c = 0; c < 25; c++) begin
        chk({nm, "_rst_no_ovalid"}, 64'(b16.out_valid), 64'd0);
        @(negedge clk);
        #1;
      end
      return;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(18 + gl));
    chk({nm, "_issues"}, 64'(nis), 64'd16);
    dup = 0;
    foreach (trace[i]) foreach (trace[j]) if (i < j && trace[i] == trace[j]) dup++;
    chk({nm, "_ran_unique"}, 64'(dup), 64'd0);
    r0 = b16.out_sh0;
    r1 = b16.out_sh1;
    chk({nm, "_result"}, r0 ^ r1, e);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      b16.in_valid = 1'b1;
      b16.in_sh0   = {$urandom, $urandom};
      #1;
      chk({nm, "_hold_ovalid"}, 64'(b16.out_valid), 64'd1);
      chk({nm, "_hold_sh0"}, b16.out_sh0, r0);
      chk({nm, "_hold_sh1"}, b16.out_sh1, r1);
      chk({nm, "_hold_in_ready"}, 64'(b16.in_ready), 64'd0);
    end
    @(negedge clk);
    b16.in_valid  = 1'b0;
    b16.out_ready = 1'b1;
    #1;
    chk({nm, "_hs_in_ready"}, 64'(b16.in_ready), 64'd0);
    chk({nm, "_hs_ovalid"}, 64'(b16.out_valid), 64'd1);
    @(negedge clk);
    b16.out_ready = 1'b0;
    #1;
    chk({nm, "_post_in_ready"}, 64'(b16.in_ready), 64'd1);
    chk({nm, "_post_ovalid"}, 64'(b16.out_valid), 64'd0);
    chk({nm, "_post_osh"}, b16.out_sh0 | b16.out_sh1, 64'd0);
  endtask

  task automatic run1(input logic [3:0] a0, input logic [3:0] a1);
    int lat;
    @(negedge clk);
    b1.in_valid  = 1'b1;
    b1.in_sh0    = a0;
    b1.in_sh1    = a1;
    b1.rnd_valid = 1'b1;
    b1.rnd_data  = 10'($urandom);
    lat = -1;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge clk);
      b1.in_valid = 1'b0;
      b1.rnd_data = 10'($urandom);
      #1;
      if (b1.out_valid) lat = k;
      else if (k == 0) begin
        chk("n1_sbox_in", 64'({b1.sbox_in0, b1.sbox_in1}), 64'({a0, a1}));
        chk("n1_sbox_ran", 64'(b1.sbox_ran), 64'(b1.rnd_data));
      end
    end
    chk("n1_latency", 64'(lat), 64'd3);
    chk("n1_result", 64'(b1.out_sh0 ^ b1.out_sh1), 64'(sb(a0 ^ a1)));
    @(negedge clk);
    b1.out_ready = 1'b1;
    @(negedge clk);
    b1.out_ready = 1'b0;
    #1;
    chk("n1_post_in_ready", 64'(b1.in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] m;
    b16.in_valid = 1'b0; b16.in_sh0 = '0; b16.in_sh1 = '0;
    b16.rnd_valid = 1'b0; b16.rnd_data = '0; b16.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_sh0 = '0; b1.in_sh1 = '0;
    b1.rnd_valid = 1'b0; b1.rnd_data = '0; b1.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(b16.in_ready), 64'd1);
    chk("rst_rnd_ready", 64'(b16.rnd_ready), 64'd0);
    chk("rst_out_valid", 64'(b16.out_valid), 64'd0);
    chk("rst_sbox", 64'({b16.sbox_ran, b16.sbox_in0, b16.sbox_in1}), 64'd0);
    chk("rst_out_sh", b16.out_sh0 | b16.out_sh1, 64'd0);
    chk("rst_n1_in_ready", 64'(b1.in_ready), 64'd1);

    run16(64'h0123456789ABCDEF, 64'd0, 99, 0, 0, -1, "vec");
    for (int t = 0; t < 3; t++) begin
      m = {$urandom, $urandom};
      run16({$urandom, $urandom} ^ m, m, 99, 0, 0, -1, "rand");
    end
    m = {$urandom, $urandom};
    run16({$urandom, $urandom}, m, 5, 3, 0, -1, "gap");
    m = {$urandom, $urandom};
    run16({$urandom, $urandom}, m, 99, 0, 10, -1, "hold");
    m = {$urandom, $urandom};
    run16({$urandom, $urandom}, m, 99, 0, 0, 8, "rst8");
    m = {$urandom, $urandom};
    run16({$urandom, $urandom}, m, 99, 0, 0, -1, "after_rst");
    for (int t = 0; t < 3; t++) run1(4'($urandom), 4'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
